// File: rtl/systolic_job_arbiter.sv
// systolic_job_arbiter
//
// Purpose: shares one 4x4 byte-matrix multiply engine between two requesters.
// A round-robin arbiter in IDLE picks a job, latches its operands, pulses the
// engine through reset (LAUNCH), lets it run (RUN), captures its result
// (CAPTURE) and presents the result until the consumer takes it (RESP).
//
// Optional build macro: SYS_ARB_TIMEOUT_EN
//   Defined   : RUN is bounded by TIMEOUT_CYCLES; an overrun goes through TOUT,
//               which returns an all-zero result with rsp_err = 1.
//   Undefined : RUN waits for eng_completed indefinitely; rsp_err is tied 0.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A valid holder keeps its payload stable until that edge; ready
// may depend combinationally on valid (req*_ready does), never the reverse.
//
// Ports
//   clk, st_rst              clock, asynchronous active-high reset
//   req{0,1}_valid/_ready    job offer / acceptance per requester
//   req{0,1}_A, req{0,1}_B   4x4 byte operands, row r at [127-32r -: 32]
//   eng_st_rst               engine reset (1 = hold engine idle)
//   eng_A, eng_B             latched operands to the engine
//   eng_C, eng_completed     engine result (16-bit elements) and done flag
//   rsp_valid/_ready         result handshake
//   rsp_id, rsp_C, rsp_err   result owner, result matrix, timeout flag
//   busy                     high whenever the FSM is not in IDLE
//   jobs_done                completed response handshakes (wraps)
//   dbg_state                current FSM state encoding

module systolic_job_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         st_rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_A,
  input  logic [127:0] req1_A,
  input  logic [127:0] req0_B,
  input  logic [127:0] req1_B,
  output logic         eng_st_rst,
  output logic [127:0] eng_A,
  output logic [127:0] eng_B,
  input  logic [255:0] eng_C,
  input  logic         eng_completed,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [255:0] rsp_C,
  output logic         rsp_err,
  output logic         busy,
  output logic [15:0]  jobs_done,
  output logic [2:0]   dbg_state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("systolic_job_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

`ifdef SYS_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4,
    S_TOUT    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  // rr_ptr = 0 favours req0 on a tie, 1 favours req1.
  logic rr_ptr;
  logic grant0;
  logic grant1;
  logic accept;

`ifdef SYS_ARB_TIMEOUT_EN
  // run_cnt holds the number of RUN cycles already spent; the cycle in which
  // it equals TOUT_LAST is the last one allowed before the abort.
  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] run_cnt;
`endif

  // Arbitration: only in IDLE, exactly one grant, tie broken by rr_ptr.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && (!req1_valid || !rr_ptr)) grant0 = 1'b1;
      else if (req1_valid)                         grant1 = 1'b1;
    end
  end

  assign accept = grant0 | grant1;

  // State register.
  always_ff @(posedge clk or posedge st_rst) begin
    if (st_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. eng_completed is only looked at in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_RUN;
      S_RUN: begin
        if (eng_completed) state_nxt = S_CAPTURE;
`ifdef SYS_ARB_TIMEOUT_EN
        else if (run_cnt == TOUT_LAST) state_nxt = S_TOUT;
`endif
      end
      S_CAPTURE: state_nxt = S_RESP;
`ifdef SYS_ARB_TIMEOUT_EN
      S_TOUT:    state_nxt = S_RESP;
`endif
      S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state. The engine runs only in RUN, so it always
  // sees at least CAPTURE/RESP/IDLE/LAUNCH in reset between two jobs.
  always_comb begin
    eng_st_rst = (state != S_RUN);
    rsp_valid  = (state == S_RESP);
    busy       = (state != S_IDLE);
    req0_ready = grant0;
    req1_ready = grant1;
    dbg_state  = state;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge st_rst) begin
    if (st_rst) begin
      rr_ptr    <= 1'b0;
      eng_A     <= '0;
      eng_B     <= '0;
      rsp_id    <= 1'b0;
      rsp_C     <= '0;
      jobs_done <= '0;
    end else begin
      if (accept) begin
        eng_A  <= grant1 ? req1_A : req0_A;
        eng_B  <= grant1 ? req1_B : req0_B;
        rsp_id <= grant1;
        // Favour whichever requester did not win this time.
        rr_ptr <= grant0;
      end
      if (state == S_CAPTURE) rsp_C <= eng_C;
`ifdef SYS_ARB_TIMEOUT_EN
      if (state == S_TOUT) rsp_C <= '0;
`endif
      if (state == S_RESP && rsp_ready) jobs_done <= jobs_done + 16'd1;
    end
  end

`ifdef SYS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge st_rst) begin
    if (st_rst) begin
      run_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == S_LAUNCH)   run_cnt <= '0;
      else if (state == S_RUN) run_cnt <= run_cnt + 8'd1;
      if (state == S_CAPTURE)   rsp_err <= 1'b0;
      else if (state == S_TOUT) rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// tb_systolic_job_arbiter
//
// Bench for systolic_job_arbiter. A behavioural engine stub multiplies the
// operands it is given and raises eng_completed after a programmable number
// of extra RUN cycles (or never). The reference model tracks which requester
// should win (last winner loses a tie), the expected matrix product, the
// expected latency and the response count.

module tb_systolic_job_arbiter;

  localparam int TIMEOUT = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic st_rst;
  always #5 clk = ~clk;

  // DUT signals
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_A, req1_A, req0_B, req1_B;
  logic         eng_st_rst;
  logic [127:0] eng_A, eng_B;
  logic [255:0] eng_C;
  logic         eng_completed;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [255:0] rsp_C;
  logic [15:0]  jobs_done;
  logic [2:0]   dbg_state;

  systolic_job_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .st_rst(st_rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_A(req0_A), .req1_A(req1_A), .req0_B(req0_B), .req1_B(req1_B),
    .eng_st_rst(eng_st_rst), .eng_A(eng_A), .eng_B(eng_B),
    .eng_C(eng_C), .eng_completed(eng_completed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_C(rsp_C), .rsp_err(rsp_err), .busy(busy),
    .jobs_done(jobs_done), .dbg_state(dbg_state)
  );

  // Reference matrix product: C[r][c] = sum_k A[r][k]*B[k][c], 16-bit.
  function automatic logic [255:0] mat_mul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] c;
    int s;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'(a[127-8*(4*r+k) -: 8]) * int'(b[127-8*(4*k+col) -: 8]);
        c[255-16*(4*r+col) -: 16] = s[15:0];
      end
    end
    return c;
  endfunction

  // Engine stub: counts cycles out of reset, done when count hits eng_lat.
  // eng_spur forces the done flag regardless of engine state.
  int eng_lat  = 0;
  bit eng_hang = 1'b0;
  bit eng_spur = 1'b0;
  int run_cnt  = 0;
  always @(posedge clk) run_cnt <= eng_st_rst ? 0 : run_cnt + 1;
  assign eng_completed = eng_spur || (!eng_st_rst && !eng_hang && run_cnt == eng_lat);
  assign eng_C = mat_mul(eng_A, eng_B);

  // Scoreboard
  int vectors     = 0;
  int miscompares = 0;
  int last_gnt    = 1;   // model: last winner; 1 after reset so req0 is favoured
  int exp_jobs    = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    st_rst = 1'b1;
    #1;
    check("rst_eng_st_rst", eng_st_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_eng_A", eng_A, 128'd0);
    check("rst_eng_B", eng_B, 128'd0);
    check("rst_rsp_C", rsp_C, 256'd0);
    check("rst_jobs_done", jobs_done, 16'd0);
    @(negedge clk);
    st_rst   = 1'b0;
    last_gnt = 1;
    exp_jobs = 0;
  endtask

  // Driver: offer a job with the given valids, run it through, hold the
  // response for 'hold' cycles, then complete the handshake.
  task automatic do_job(input bit v0, input bit v1, input int lat, input bit hang, input int hold);
    int exp_id, cyc, run_end, exp_cyc;
    logic [127:0] a, b;
    logic [255:0] c_exp;
    bit exp_err;
    exp_id = (v0 && v1) ? (1 - last_gnt) : (v1 ? 1 : 0);
    a = (exp_id == 1) ? req1_A : req0_A;
    b = (exp_id == 1) ? req1_B : req0_B;
    if (hang) begin
      run_end = TIMEOUT + 2;
      exp_cyc = TIMEOUT + 3;
      exp_err = 1'b1;
      exp_q.push_back(256'd0);
    end else begin
      run_end = lat + 3;
      exp_cyc = lat + 4;
      exp_err = 1'b0;
      exp_q.push_back(mat_mul(a, b));
    end

    @(negedge clk);
    eng_lat    = lat;
    eng_hang   = hang;
    req0_valid = v0;
    req1_valid = v1;
    #1;
    check("grant0", req0_ready, exp_id == 0);
    check("grant1", req1_ready, exp_id == 1);
    check("idle_busy", busy, 1'b0);
    @(posedge clk);
    last_gnt = exp_id;

    // Walk the job one cycle at a time; valids stay high so any early
    // grant would show up on the ready lines.
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req0_A = rand128(); req0_B = rand128();
        req1_A = rand128(); req1_B = rand128();
      end
      #1;
      check("ready_while_busy", {req0_ready, req1_ready}, 2'b00);
      if (!rsp_valid) check("eng_st_rst_phase", eng_st_rst, !(cyc >= 2 && cyc < run_end));
      if (cyc == 1) begin
        check("launch_eng_A", eng_A, a);
        check("launch_eng_B", eng_B, b);
        check("launch_busy", busy, 1'b1);
      end
    end while (!rsp_valid && cyc < 200);
    check("latency", cyc, exp_cyc);

    c_exp = exp_q.pop_front();
    check("rsp_id", rsp_id, exp_id);
    check("rsp_C", rsp_C, c_exp);
    check("rsp_err", rsp_err, exp_err);
    check("jobs_before", jobs_done, exp_jobs[15:0]);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      eng_spur = 1'b1;
      #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_C", rsp_C, c_exp);
      check("hold_id", rsp_id, exp_id);
      check("hold_err", rsp_err, exp_err);
      check("hold_ready", {req0_ready, req1_ready}, 2'b00);
      check("hold_eng_rst", eng_st_rst, 1'b1);
    end

    @(negedge clk);
    eng_spur  = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("hs_valid", rsp_valid, 1'b1);
    check("hs_ready_excl", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk);
    exp_jobs++;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("post_busy", busy, 1'b0);
    check("post_valid", rsp_valid, 1'b0);
    check("post_jobs", jobs_done, exp_jobs[15:0]);
    check("post_next_grant", req0_ready | req1_ready, v0 | v1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int v;
    st_rst     = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;

    // Power-on reset state
    #1;
    check("por_eng_st_rst", eng_st_rst, 1'b1);
    check("por_rsp_valid", rsp_valid, 1'b0);
    check("por_jobs_done", jobs_done, 16'd0);
    check("por_rsp_C", rsp_C, 256'd0);
    repeat (3) @(negedge clk);
    st_rst = 1'b0;

    // Known matrices on req0 only
    req0_A = 128'h0102030405060708090a0b0c0d0e0f10;
    req0_B = 128'h1112131415161718191a1b1c1d1e1f20;
    do_job(1'b1, 1'b0, 3, 1'b0, 0);
    check("known_C00", rsp_C[255 -: 16], 16'd250);
    check("known_C33", rsp_C[15:0], 16'd1528);
    check("known_jobs", jobs_done, 16'd1);

    // Reset restores the req0-favouring pointer; then alternate 0,1,0
    pulse_reset();
    for (int j = 0; j < 3; j++) begin
      req0_A = rand128(); req0_B = rand128();
      req1_A = rand128(); req1_B = rand128();
      do_job(1'b1, 1'b1, $urandom_range(0, 5), 1'b0, 0);
      check("alt_order", rsp_id, j % 2);
    end

    // Long response stall, spurious done flag during it
    req1_A = rand128(); req1_B = rand128();
    do_job(1'b0, 1'b1, 2, 1'b0, 20);

    // Reset in the middle of RUN discards the job
    @(negedge clk);
    req0_A = rand128(); req0_B = rand128();
    eng_lat = 30; eng_hang = 1'b0;
    req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("midrun_running", eng_st_rst, 1'b0);
    st_rst = 1'b1;
    #1;
    check("midrun_eng_rst", eng_st_rst, 1'b1);
    check("midrun_busy", busy, 1'b0);
    check("midrun_valid", rsp_valid, 1'b0);
    @(negedge clk);
    st_rst   = 1'b0;
    last_gnt = 1;
    exp_jobs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      check("discard_no_rsp", {rsp_valid, busy}, 2'b00);
    end
    req1_A = rand128(); req1_B = rand128();
    do_job(1'b0, 1'b1, 4, 1'b0, 1);

    // Randomized jobs
    for (int n = 0; n < 12; n++) begin
      v = $urandom_range(1, 3);
      req0_A = rand128(); req0_B = rand128();
      req1_A = rand128(); req1_B = rand128();
      do_job(v[0], v[1], $urandom_range(0, 8), 1'b0, $urandom_range(0, 3));
    end

`ifdef SYS_ARB_TIMEOUT_EN
    // Engine never finishes: abort after TIMEOUT RUN cycles
    req0_A = rand128(); req0_B = rand128();
    do_job(1'b1, 1'b0, 0, 1'b1, 2);
    // Done in the very cycle the limit is hit: normal result wins
    req1_A = rand128(); req1_B = rand128();
    do_job(1'b0, 1'b1, TIMEOUT - 1, 1'b0, 0);
    // One cycle inside the limit
    req0_A = rand128(); req0_B = rand128();
    do_job(1'b1, 1'b0, TIMEOUT - 2, 1'b0, 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
